bcd_display_driver: RTL and testbench



---
 rtl/bcd_display_driver_pkg.sv | 32 +++
 rtl/bcd_display_driver_seg7_encode.sv | 9 +
 rtl/bcd_display_driver.sv | 88 ++++++++
 tb/tb_bcd_display_driver.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bcd_display_driver_pkg.sv
// bcd_display_driver_pkg: segment codes, limits and state encoding shared by the display driver
package bcd_display_driver_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam int DP_BIT = 7;
  localparam logic [19:0] BCD_MAX = 20'd999999;
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return 7'h00;
    endcase
  endfunction
endpackage

// File: rtl/bcd_display_driver_seg7_encode.sv
// seg7_encode: BCD nibble to {g..a} segment pattern, non-decimal codes dark
module seg7_encode
  import bcd_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = seg_code(nibble);
endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: sequential double-dabble of a binary value into six 7-segment digits with blanking, dp and overflow
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             blank_en,
  input  logic [5:0]       dp_pos,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [7:0]       digit5,
  output logic [7:0]       digit4,
  output logic [7:0]       digit3,
  output logic [7:0]       digit2,
  output logic [7:0]       digit1,
  output logic [7:0]       digit0,
  output logic [5:0]       disp_enable
);
  state_t state, next;
  logic [WIDTH-1:0] bin;
  logic [23:0] bcd, adj;
  logic [4:0] cnt;
  logic blank_q, ovf_p;
  logic [5:0] dp_q, en;
  logic [6:0] seg [6];
  logic [7:0] dig [6];
  assign busy = state != IDLE;
  assign {digit5, digit4, digit3, digit2, digit1, digit0} = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
  always_comb begin
    next = state == IDLE ? (load ? SHIFT : IDLE) :
           state == SHIFT ? (cnt == 5'd0 ? UPDATE : SHIFT) : IDLE;
  end
  // add-3 per nibble, no carry across nibbles
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 6; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  always_comb begin
    en = '0;
    for (int i = 0; i < 6; i++)
      en[i] = ovf_p | ~blank_q | (i == 0) | (|(bcd >> (4*i))) | dp_q[i];
  end
  for (genvar g = 0; g < 6; g++) begin : g_enc
    seg7_encode u_enc (.nibble(bcd[4*g+:4]), .seg(seg[g]));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      blank_q <= 1'b0;
      dp_q <= '0;
      ovf_p <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      disp_enable <= '0;
      for (int i = 0; i < 6; i++) dig[i] <= '0;
    end else begin
      state <= next;
      done <= state == UPDATE;
      if (state == IDLE && load) begin
        bin <= value;
        bcd <= '0;
        blank_q <= blank_en;
        dp_q <= dp_pos;
        ovf_p <= value > WIDTH'(BCD_MAX);
        cnt <= 5'(WIDTH - 1);
      end
      if (state == SHIFT) begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt <= cnt - 5'd1;
      end
      if (state == UPDATE) begin
        ovf <= ovf_p;
        disp_enable <= en;
        for (int i = 0; i < 6; i++)
          dig[i] <= ovf_p ? {dp_q[i], SEG_MINUS} : {dp_q[i], seg[i]};
      end
    end
  end
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed and random checks against an arithmetic reference of the display driver
module tb_bcd_display_driver;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, blank_en = 1'b0;
  logic [19:0] value = '0;
  logic [5:0] dp_pos = '0;
  logic busy, done, ovf;
  logic [7:0] digit5, digit4, digit3, digit2, digit1, digit0;
  logic [5:0] disp_enable;
  logic [7:0] dd [6];
  logic [7:0] exp_d [6];
  logic [7:0] prev_d [6];
  logic [5:0] exp_en, prev_en;
  logic exp_ovf;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int total = 0, passed = 0;
  bcd_display_driver dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_en(blank_en), .dp_pos(dp_pos),
    .busy(busy), .done(done), .ovf(ovf), .digit5(digit5), .digit4(digit4), .digit3(digit3),
    .digit2(digit2), .digit1(digit1), .digit0(digit0), .disp_enable(disp_enable)
  );
  always #5 clk = ~clk;
  always_comb begin
    dd[0] = digit0; dd[1] = digit1; dd[2] = digit2;
    dd[3] = digit3; dd[4] = digit4; dd[5] = digit5;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic model(input int v, input logic b, input logic [5:0] dp);
    int p = 1;
    exp_ovf = v > 999999;
    for (int i = 0; i < 6; i++) begin
      exp_d[i] = exp_ovf ? {dp[i], 7'h40} : {dp[i], segtab[(v / p) % 10]};
      exp_en[i] = exp_ovf || !b || i == 0 || (v / p) != 0 || dp[i];
      p *= 10;
    end
  endtask
  task automatic zero_prev();
    for (int i = 0; i < 6; i++) prev_d[i] = '0;
    prev_en = '0;
  endtask
  task automatic check_zeroed(input string tag);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_digit%0d", tag, i), 32'(dd[i]), 0);
    chk({tag, "_en"}, 32'(disp_enable), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask
  task automatic do_conv(input int v, input logic b, input logic [5:0] dp, input bit inject);
    int n = 0;
    model(v, b, dp);
    @(negedge clk);
    value = 20'(v); blank_en = b; dp_pos = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_after_load", 32'(busy), 1);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (inject && n == 5) begin
        load = 1'b1; value = 20'(v ^ 20'h5A5A5); blank_en = ~b; dp_pos = ~dp;
      end else load = 1'b0;
      if (n == 10) begin
        chk("hold_digit0", 32'(digit0), 32'(prev_d[0]));
        chk("hold_en", 32'(disp_enable), 32'(prev_en));
      end
    end
    chk($sformatf("latency_%0d", v), n, 21);
    for (int i = 0; i < 6; i++) chk($sformatf("v%0d_digit%0d", v, i), 32'(dd[i]), 32'(exp_d[i]));
    chk($sformatf("v%0d_en", v), 32'(disp_enable), 32'(exp_en));
    chk($sformatf("v%0d_ovf", v), 32'(ovf), 32'(exp_ovf));
    chk("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    chk("done_drop", 32'(done), 0);
    prev_d = exp_d;
    prev_en = exp_en;
  endtask
  initial begin
    int seen;
    zero_prev();
    repeat (2) @(negedge clk);
    check_zeroed("por");
    reset = 1'b0;
    do_conv(123456, 1'b1, 6'b000000, 1'b0);
    do_conv(42, 1'b1, 6'b000000, 1'b0);
    do_conv(42, 1'b0, 6'b000000, 1'b0);
    do_conv(0, 1'b1, 6'b000000, 1'b0);
    do_conv(5, 1'b1, 6'b000100, 1'b0);
    do_conv(1000000, 1'b1, 6'b000000, 1'b0);
    do_conv(999999, 1'b1, 6'b000000, 1'b0);
    do_conv(1048575, 1'b0, 6'b101010, 1'b0);
    do_conv(7080, 1'b1, 6'b010000, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zeroed("idle_rst");
    @(negedge clk);
    reset = 1'b0;
    zero_prev();
    @(negedge clk);
    value = 20'd314159; blank_en = 1'b1; dp_pos = 6'b000001; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zeroed("abort");
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    check_zeroed("abort_after");
    do_conv(271828, 1'b1, 6'b000010, 1'b0);
    for (int k = 0; k < 10; k++) begin
      int v;
      v = (k % 3 == 0) ? int'($urandom_range(0, 999)) :
          (k % 3 == 1) ? int'($urandom_range(0, 999999)) : int'($urandom_range(0, 1048575));
      do_conv(v, 1'($urandom), 6'($urandom), k == 4);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
